// File: rtl/softmax_avg_argmax.sv
// Final inference stage: averages the current softmax output with up to two retained
// outputs, writes the averages, retires history and reports the argmax sleep stage.
module softmax_avg_argmax #(
   parameter int NUM_STAGES = 5,
   parameter int DATA_W     = 9,
   parameter int ADDR_W     = 16,
   parameter int CUR_BASE   = 32,
   parameter int PREV_BASE  = 57334,
   parameter int AVG_BASE   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              clear_hist,
   output logic              busy,
   output logic              done,
   output logic [2:0]        sleep_stage,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
);

   localparam int SUM_W  = DATA_W + 2;
   localparam int PROD_W = SUM_W + 11;

   localparam logic [2:0]        LAST_STAGE = 3'(NUM_STAGES - 1);
   localparam logic [ADDR_W-1:0] CUR_A      = ADDR_W'(CUR_BASE);
   localparam logic [ADDR_W-1:0] SLOT0_A    = ADDR_W'(PREV_BASE);
   localparam logic [ADDR_W-1:0] SLOT1_A    = ADDR_W'(PREV_BASE + NUM_STAGES);
   localparam logic [ADDR_W-1:0] AVG_A      = ADDR_W'(AVG_BASE);

   localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-(2 ** (DATA_W - 1)));

   typedef enum logic [3:0] {
      S_IDLE, S_LAUNCH, S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [2:0]              stage_q;
   logic [1:0]              hist_cnt_q;
   logic [DATA_W-1:0]       cur_q, p0_q, avg_q;
   logic signed [SUM_W-1:0] max_sum_q;
   logic [2:0]              max_idx_q;

   logic [DATA_W-1:0]        p0m, p1m;
   logic signed [SUM_W-1:0]  sum;
   logic [9:0]               recip;
   logic signed [PROD_W-1:0] sum_ext, recip_ext, prod, avg_raw;
   logic [DATA_W-1:0]        avg_sat;
   logic [ADDR_W-1:0]        stage_off;

   assign stage_off = {{(ADDR_W-3){1'b0}}, stage_q};

   // Masked history, exact sum and reciprocal scaling; p1 is used straight off the read bus in P3.
   always_comb begin
      p0m = (hist_cnt_q >= 2'd1) ? p0_q : '0;
      p1m = (hist_cnt_q == 2'd2) ? mem_rd_data : '0;
      sum = $signed({{2{cur_q[DATA_W-1]}}, cur_q}) + $signed({{2{p0m[DATA_W-1]}}, p0m})
          + $signed({{2{p1m[DATA_W-1]}}, p1m});
      case (hist_cnt_q)
         2'd0:    recip = 10'd512;
         2'd1:    recip = 10'd256;
         default: recip = 10'd171;
      endcase
      sum_ext   = {{(PROD_W-SUM_W){sum[SUM_W-1]}}, sum};
      recip_ext = {{(PROD_W-10){1'b0}}, recip};
      prod      = sum_ext * recip_ext;
      avg_raw   = prod >>> 9;
      if (avg_raw > SAT_HI)      avg_sat = SAT_HI[DATA_W-1:0];
      else if (avg_raw < SAT_LO) avg_sat = SAT_LO[DATA_W-1:0];
      else                       avg_sat = avg_raw[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Seven phases per stage: three reads, one compute slot, three writes.
   always_comb begin
      state_d     = state_q;
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_DONE);
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      case (state_q)
         S_IDLE:   if (start) state_d = S_LAUNCH;
         S_LAUNCH: state_d = S_P0;
         S_P0: begin
            state_d   = S_P1;
            mem_rd_en = 1'b1;
            mem_addr  = CUR_A + stage_off;
         end
         S_P1: begin
            state_d   = S_P2;
            mem_rd_en = 1'b1;
            mem_addr  = SLOT0_A + stage_off;
         end
         S_P2: begin
            state_d   = S_P3;
            mem_rd_en = 1'b1;
            mem_addr  = SLOT1_A + stage_off;
         end
         S_P3: state_d = S_P4;
         S_P4: begin
            state_d     = S_P5;
            mem_wr_en   = 1'b1;
            mem_addr    = AVG_A + stage_off;
            mem_wr_data = avg_q;
         end
         S_P5: begin
            state_d     = S_P6;
            mem_wr_en   = 1'b1;
            mem_addr    = SLOT1_A + stage_off;
            mem_wr_data = p0m;
         end
         S_P6: begin
            state_d     = (stage_q == LAST_STAGE) ? S_DONE : S_P0;
            mem_wr_en   = 1'b1;
            mem_addr    = SLOT0_A + stage_off;
            mem_wr_data = cur_q;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath captures, argmax tracking and history bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q     <= '0;
         hist_cnt_q  <= '0;
         cur_q       <= '0;
         p0_q        <= '0;
         avg_q       <= '0;
         max_sum_q   <= '0;
         max_idx_q   <= '0;
         sleep_stage <= '0;
      end else begin
         if (state_q == S_IDLE && clear_hist)
            hist_cnt_q <= '0;
         if (state_q == S_DONE && hist_cnt_q != 2'd2)
            hist_cnt_q <= hist_cnt_q + 2'd1;
         if (state_q == S_LAUNCH)
            stage_q <= '0;
         if (state_q == S_P6)
            stage_q <= stage_q + 3'd1;
         if (state_q == S_P1)
            cur_q <= mem_rd_data;
         if (state_q == S_P2)
            p0_q <= mem_rd_data;
         if (state_q == S_P3) begin
            avg_q <= avg_sat;
            if (stage_q == 3'd0 || sum > max_sum_q) begin
               max_sum_q <= sum;
               max_idx_q <= stage_q;
            end
         end
         if (state_q == S_P6 && stage_q == LAST_STAGE)
            sleep_stage <= max_idx_q;
      end
   end

endmodule
